// File: rtl/ula_pilha_seq.sv
// ALU sequencer for the stack datapath: pops one or two operands, computes, and
// pushes the 32-bit result back onto the operand stack.
module ula_pilha_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] pilha_dout,
  input  logic [15:0] pilha_tos,
  output logic        pop_req,
  output logic        push_req,
  output logic [31:0] res,
  output logic        zero,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  localparam int unsigned DW = 16;
  localparam int unsigned RW = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_LT  = 3'b111;

  typedef enum logic [3:0] {
    IDLE, CHECK, POP_A, CAP_A, POP_B, CAP_B, EXEC, PUSH, ERR
  } state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [DW-1:0] diff_c;
  logic [DW-1:0] need_c;
  logic [RW-1:0] alu_c;

  assign diff_c = b_q - a_q;
  assign need_c = (op_q == OP_NOT) ? DW'(1) : DW'(2);

  // Result of the latched operation on the captured operands
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_ADD:  alu_c = {15'b0, 17'(b_q) + 17'(a_q)};
      OP_SUB:  alu_c = {{16{diff_c[15]}}, diff_c};
      OP_MUL:  alu_c = RW'(b_q) * RW'(a_q);
      OP_AND:  alu_c = {16'b0, b_q & a_q};
      OP_OR:   alu_c = {16'b0, b_q | a_q};
      OP_XOR:  alu_c = {16'b0, b_q ^ a_q};
      OP_NOT:  alu_c = {16'b0, ~a_q};
      OP_LT:   alu_c = {31'b0, b_q < a_q};
      default: alu_c = '0;
    endcase
  end

  // Sequencer; pulse outputs are set on entry to the state that owns them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res      <= '0;
      zero     <= 1'b0;
      pop_req  <= 1'b0;
      push_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      erro     <= 1'b0;
    end else begin
      pop_req  <= 1'b0;
      push_req <= 1'b0;
      done     <= 1'b0;
      erro     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (pilha_tos < need_c) begin
            erro  <= 1'b1;
            state <= ERR;
          end else begin
            pop_req <= 1'b1;
            state   <= POP_A;
          end
        end
        POP_A: state <= CAP_A;
        CAP_A: begin
          a_q <= pilha_dout;
          if (op_q == OP_NOT) begin
            state <= EXEC;
          end else begin
            pop_req <= 1'b1;
            state   <= POP_B;
          end
        end
        POP_B: state <= CAP_B;
        CAP_B: begin
          b_q   <= pilha_dout;
          state <= EXEC;
        end
        EXEC: begin
          res      <= alu_c;
          zero     <= (alu_c == '0);
          push_req <= 1'b1;
          done     <= 1'b1;
          state    <= PUSH;
        end
        PUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_pilha_seq.sv
// Directed bench for ula_pilha_seq: per-cycle activity masks and results
// checked against hand-computed values.
module tb_ula_pilha_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [15:0] pilha_dout;
  logic [15:0] pilha_tos;
  logic        pop_req;
  logic        push_req;
  logic [31:0] res;
  logic        zero;
  logic        busy;
  logic        done;
  logic        erro;

  int checks   = 0;
  int failures = 0;

  logic [15:0] pop_m, push_m, done_m, busy_m, erro_m;
  logic [31:0] res_p;
  logic        zero_p;
  logic [15:0] acc_push, acc_busy;
  int          budget;

  ula_pilha_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .pilha_dout(pilha_dout), .pilha_tos(pilha_tos),
    .pop_req(pop_req), .push_req(push_req), .res(res), .zero(zero),
    .busy(busy), .done(done), .erro(erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command at edge 0 and record cycles 1..12; smask drives start per cycle
  task automatic run_op(input logic [2:0] o, input logic [15:0] tos,
                        input logic [15:0] va, input logic [15:0] vb,
                        input logic [15:0] smask);
    int pidx;
    pidx = 0;
    pop_m = '0; push_m = '0; done_m = '0; busy_m = '0; erro_m = '0;
    res_p = '0; zero_p = 1'b0;
    op = o; pilha_tos = tos; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      start = smask[k];
      pop_m[k]  = pop_req;
      push_m[k] = push_req;
      done_m[k] = done;
      busy_m[k] = busy;
      erro_m[k] = erro;
      if (push_req) begin
        res_p  = res;
        zero_p = zero;
      end
      if (pop_req) begin
        pilha_dout = (pidx == 0) ? va : vb;
        pidx++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; pilha_dout = '0; pilha_tos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {19'b0, pop_req, push_req, done, erro, busy, zero, 8'b0},
        32'h0);
    chk("reset_res", res, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD 0xFFFF + 0x0001
    run_op(3'b000, 16'd2, 16'h0001, 16'hFFFF, 16'h0);
    chk("add_pop", 32'(pop_m), 32'h0014);
    chk("add_push", 32'(push_m), 32'h0080);
    chk("add_done", 32'(done_m), 32'h0080);
    chk("add_busy", 32'(busy_m), 32'h00FE);
    chk("add_res", res_p, 32'h0001_0000);
    chk("add_zero", 32'(zero_p), 32'h0);

    run_op(3'b001, 16'd2, 16'h0005, 16'h0003, 16'h0);
    chk("sub_res", res_p, 32'hFFFF_FFFE);

    run_op(3'b010, 16'd2, 16'hFFFF, 16'hFFFF, 16'h0);
    chk("mul_res", res_p, 32'hFFFE_0001);

    // Underflow on binary op; result must hold MUL value
    run_op(3'b000, 16'd1, 16'h1111, 16'h2222, 16'h0);
    chk("uf_add_erro", 32'(erro_m), 32'h0004);
    chk("uf_add_pop", 32'(pop_m), 32'h0);
    chk("uf_add_push", 32'(push_m), 32'h0);
    chk("uf_add_busy", 32'(busy_m), 32'h0006);
    chk("uf_add_res_hold", res, 32'hFFFE_0001);

    run_op(3'b011, 16'd2, 16'hF0F0, 16'hFF00, 16'h0);
    chk("and_res", res_p, 32'h0000_F000);
    run_op(3'b100, 16'd2, 16'hF0F0, 16'hFF00, 16'h0);
    chk("or_res", res_p, 32'h0000_FFF0);
    run_op(3'b101, 16'd2, 16'h0F0F, 16'h00FF, 16'h0);
    chk("xor_res", res_p, 32'h0000_0FF0);
    run_op(3'b111, 16'd2, 16'h0005, 16'h0003, 16'h0);
    chk("lt_true", res_p, 32'h1);
    run_op(3'b111, 16'd2, 16'h0003, 16'h0005, 16'h0);
    chk("lt_false", res_p, 32'h0);
    chk("lt_false_zero", 32'(zero_p), 32'h1);

    // NOT: single pop
    run_op(3'b110, 16'd1, 16'hFFFF, 16'h1234, 16'h0);
    chk("not_pop", 32'(pop_m), 32'h0004);
    chk("not_push", 32'(push_m), 32'h0020);
    chk("not_busy", 32'(busy_m), 32'h003E);
    chk("not_res", res_p, 32'h0);
    chk("not_zero", 32'(zero_p), 32'h1);

    run_op(3'b110, 16'd0, 16'h0000, 16'h0000, 16'h0);
    chk("uf_not_erro", 32'(erro_m), 32'h0004);
    chk("uf_not_pop", 32'(pop_m), 32'h0);
    chk("uf_not_push", 32'(push_m), 32'h0);
    chk("uf_not_busy", 32'(busy_m), 32'h0006);

    // Starts while busy are ignored
    run_op(3'b000, 16'd2, 16'h0002, 16'h0003, 16'h0088);
    chk("ovl_push", 32'(push_m), 32'h0080);
    chk("ovl_done", 32'(done_m), 32'h0080);
    chk("ovl_busy", 32'(busy_m), 32'h00FE);
    chk("ovl_res", res_p, 32'h0000_0005);

    // Start in the first IDLE cycle is accepted
    run_op(3'b000, 16'd2, 16'h0002, 16'h0003, 16'h0100);
    chk("b2b_busy", 32'(busy_m), 32'h1EFE);
    chk("b2b_pop", 32'(pop_m), 32'h1414);
    budget = 0;
    while (busy && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("b2b_drain", 32'(busy), 32'h0);

    // Asynchronous reset during POP_B
    op = 3'b010; pilha_tos = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_pop_b", 32'(pop_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {25'b0, pop_req, push_req, done, erro, busy, zero, 1'b0},
        32'h0);
    chk("rst_async_res", res, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_push = '0; acc_busy = '0;
    for (int k = 0; k < 12; k++) begin
      acc_push[k] = push_req;
      acc_busy[k] = busy;
      @(posedge clk); #1;
    end
    chk("rst_no_push", 32'(acc_push), 32'h0);
    chk("rst_idle", 32'(acc_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
